// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide/remainder sequencer.
//   DIV_XLEN     default operand/result width
//   div_op_e     op encoding as presented on the op port
//   div_state_e  sequencer states
package div_pkg;

    localparam int unsigned DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // DIV and REM treat operands as two's complement; the U variants do not.
    function automatic logic op_signed(div_op_e op);
        return ~op[0];
    endfunction

    // REM/REMU return the remainder; DIV/DIVU return the quotient.
    function automatic logic op_is_rem(div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of restoring shift-subtract division.
//   rem_i/dvd_i/dvs_i  partial remainder, remaining dividend bits, divisor
//   rem_o/dvd_o        updated partial remainder and dividend
//   q_o                quotient bit produced by this iteration
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvd_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] dvd_o,
    output logic            q_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // The shifted remainder keeps its carry-out bit so divisors with the MSB
    // set still compare correctly; diff[XLEN] is the borrow.
    always_comb begin
        rem_sh = {rem_i, dvd_i[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_i};
        q_o    = ~diff[XLEN];
        rem_o  = q_o ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        dvd_o  = {dvd_i[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer with valid/ready handshakes.
// Optional build macro: DIV_EARLY_OUT_EN (|dataA| < |dataB| finishes in one cycle).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only when idle)
//   op, dataA, dataB    operation, dividend, divisor
//   kill                flush; aborts any operation in flight
//   out_valid/out_ready result handshake, dataD holds the result
//   busy                operation in progress or result pending
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] dataD,
    output logic            busy
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic            rem_sel_q, rem_sel_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    div_op_e         op_in;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            dvs_zero, ovf, early, special, accept, last;
    logic [XLEN-1:0] spec_res, calc_res, quo_fin;
    logic [XLEN-1:0] step_rem, step_dvd;
    logic            step_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dataD     = result_q;
    assign busy      = busy_q;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd),
        .q_o   (step_q)
    );

    // Accept-time decode: operand magnitudes and the cases resolved without iterating.
    always_comb begin
        op_in    = div_op_e'(op);
        sign_a   = op_signed(op_in) & dataA[XLEN-1];
        sign_b   = op_signed(op_in) & dataB[XLEN-1];
        mag_a    = sign_a ? -dataA : dataA;
        mag_b    = sign_b ? -dataB : dataB;
        dvs_zero = (dataB == '0);
        ovf      = op_signed(op_in) && (dataA == MIN_NEG) && (dataB == '1);
`ifdef DIV_EARLY_OUT_EN
        early    = (mag_a < mag_b);
`else
        early    = 1'b0;
`endif
        special  = dvs_zero | ovf | early;
        if (dvs_zero) begin
            spec_res = op_is_rem(op_in) ? dataA : '1;
        end else if (ovf) begin
            spec_res = op_is_rem(op_in) ? '0 : MIN_NEG;
        end else begin
            spec_res = op_is_rem(op_in) ? dataA : '0;
        end
        accept   = in_valid && in_ready_q && !kill;
        last     = (state_q == CALC) && (cnt_q == CNT_LAST);
        quo_fin  = {quo_q[XLEN-2:0], step_q};
        // Quotient negated when operand signs differ; remainder follows the dividend.
        if (rem_sel_q) begin
            calc_res = rneg_q ? -step_rem : step_rem;
        end else begin
            calc_res = qneg_q ? -quo_fin : quo_fin;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
        end
    end

    // Output next values.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (accept && special) begin
                    out_valid_d = 1'b1;
                    result_d    = spec_res;
                end
            end
            CALC: begin
                if (last) begin
                    out_valid_d = 1'b1;
                    result_d    = calc_res;
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: out_valid_d = 1'b0;
        endcase
        if (kill) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // Datapath next values: load at accept, iterate in CALC.
    always_comb begin
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE && accept) begin
            rem_sel_d = op_is_rem(op_in);
            qneg_d    = sign_a ^ sign_b;
            rneg_d    = sign_a;
            dvd_d     = mag_a;
            dvs_d     = mag_b;
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = '0;
        end else if (state_q == CALC) begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            quo_d = quo_fin;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rem_sel_q   <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            rem_sel_q   <= rem_sel_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_div_seq_ctrl;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] dataA, dataB;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataD;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_done = 0;
    bit   rand_ready = 0;

    div_seq_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dataA     (dataA),
        .dataB     (dataB),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataD     (dataD),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference result straight from the RISC-V M-extension rules.
    function automatic logic [31:0] ref_result(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic sgn, is_rem;
        sgn    = (o == OP_DIV) || (o == OP_REM);
        is_rem = (o == OP_REM) || (o == OP_REMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == MIN_NEG && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : MIN_NEG;
        if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] magnitude(logic sgn, logic [31:0] v);
        if (sgn && v[31]) return 32'(0 - v);
        return v;
    endfunction

    // Cycles from the accept cycle to the first cycle with out_valid.
    function automatic int ref_latency(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic sgn;
        sgn = (o == OP_DIV) || (o == OP_REM);
        if (b == 32'd0) return 1;
        if (sgn && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (magnitude(sgn, a) < magnitude(sgn, b)) return 1;
`else
        if (magnitude(sgn, a) == 32'hFFFF_FFFF) return 33;
`endif
        return 33;
    endfunction

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid dataD=%h", dataD);
            end else begin
                cur = sb[0];
                if (!lat_done) begin
                    checks++;
                    if (cyc - cur.acc + 1 != cur.lat) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d", cyc - cur.acc + 1, cur.lat);
                    end
                    lat_done = 1;
                end
                checks++;
                if (dataD !== cur.res) begin
                    errors++;
                    $display("FAIL result got=%h exp=%h", dataD, cur.res);
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_status in_ready=%b busy=%b exp 0/1", in_ready, busy);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    lat_done = 0;
                end
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Waits for in_ready, presents one request for the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout in_ready=%b exp 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        op       = o;
        dataA    = a;
        dataB    = b;
        if (track) sb.push_back('{ref_result(o, a, b), ref_latency(o, a, b), cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        dataA    = $urandom;
        dataB    = $urandom;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) return;
        end
        checks++; errors++;
        $display("FAIL drain_timeout pending=%0d exp 0", sb.size());
    endtask

    // Runs 40 cycles and checks that no result appears.
    task automatic watch_quiet(input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        int          mode;
        bit          got_valid;

        rst = 1'b1; in_valid = 1'b0; op = 2'b00; dataA = '0; dataB = '0;
        kill = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dataD", dataD, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed values and latencies.
        issue(OP_DIVU, 32'd100, 32'd7, 1);
        issue(OP_REMU, 32'd100, 32'd7, 1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 1);
        issue(OP_REM, 32'd7, 32'hFFFF_FFFE, 1);
        issue(OP_DIVU, 32'd5, 32'd0, 1);
        issue(OP_REMU, 32'd5, 32'd0, 1);
        issue(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, 1);
        issue(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 1);
        issue(OP_DIVU, 32'd3, 32'd10, 1);
        issue(OP_REMU, 32'd3, 32'd10, 1);
        wait_drain();

        // Backpressure: result held for 5 extra cycles.
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd9, 32'd3, 1);
        got_valid = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) begin
                got_valid = 1;
                break;
            end
        end
        check("bp_out_valid_seen", 32'(got_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);

        // kill beats a same-cycle request.
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; op = OP_DIVU; dataA = 32'd8; dataB = 32'd2;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_accept_busy", 32'(busy), 32'd0);
        check("kill_accept_in_ready", 32'(in_ready), 32'd1);

        // kill at CALC cycle 10.
        issue(OP_DIVU, 32'd1000, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_in_ready", 32'(in_ready), 32'd1);
        check("kill_busy", 32'(busy), 32'd0);
        watch_quiet("kill_no_result");
        issue(OP_DIVU, 32'd20, 32'd4, 1);
        wait_drain();

        // rst at CALC cycle 10.
        issue(OP_DIVU, 32'd77, 32'd5, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_dataD", dataD, 32'd0);
        watch_quiet("rst_no_result");
        issue(OP_DIVU, 32'd20, 32'd4, 1);
        wait_drain();

        // Randomized operations with random consumer backpressure.
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            o    = 2'($urandom);
            a    = $urandom;
            b    = $urandom;
            mode = int'($urandom_range(0, 5));
            case (mode)
                0: b = 32'd0;
                1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(o, a, b, 1);
        end
        wait_drain();
        rand_ready = 0;
        #2 out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
